// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the instruction prefetch queue.
package fetch_queue_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int          WORD_BYTES   = 4;
   localparam int          ENTRY_W      = 64;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } fq_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DROP = 2'd2
   } fq_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Register-array FIFO of fetched {instr, pc4} entries; knows nothing about requests.
module fetch_fifo
   import fetch_queue_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clear,
   input  logic               i_push,
   input  logic [ENTRY_W-1:0] i_wdata,
   input  logic               i_pop,
   output logic               o_valid,
   output logic [ENTRY_W-1:0] o_rdata,
   output logic [AW:0]        o_count
);

   localparam int          CW      = AW + 1;
   localparam logic [AW:0] L_DEPTH = CW'(DEPTH);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW:0]        r_count;
   logic               w_empty;
   logic               w_full;
   logic               w_do_push;
   logic               w_do_pop;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == L_DEPTH);
   assign w_do_push = i_push & ~w_full & ~i_clear;
   assign w_do_pop  = i_pop & ~w_empty & ~i_clear;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is not reset; the head read is gated to zero while empty.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_valid = ~w_empty;
   assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Prefetch stage: one outstanding word fetch at a time, FIFO of results, redirect flush.
//   state   | meaning
//   ST_IDLE | no request outstanding
//   ST_BUSY | im_req high, waiting for im_ack (pending)
//   ST_DROP | redirected with a response still owed; next ack is discarded
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
)(
   input  logic                  clk,
   input  logic                  rst,
   output logic                  im_req,
   output logic [31:0]           im_addr,
   input  logic                  im_ack,
   input  logic [31:0]           im_rdata,
   output logic                  dq_valid,
   output logic [31:0]           dq_instr,
   output logic [31:0]           dq_pc4,
   input  logic                  dq_ready,
   input  logic                  redir_valid,
   input  logic [31:0]           redir_addr,
   output logic [$clog2(DEPTH):0] count
);

   localparam int          AW      = $clog2(DEPTH);
   localparam int          CW      = AW + 1;
   localparam logic [AW:0] L_DEPTH = CW'(DEPTH);

   fq_state_t          r_state;
   fq_state_t          w_state_nxt;
   logic [31:0]        r_fetch_pc;
   logic               w_accept;
   logic               w_push;
   logic               w_room;
   logic [AW:0]        w_count;
   logic [AW:0]        w_cnt_push;
   fq_entry_t          w_wentry;
   fq_entry_t          w_head;
   logic [ENTRY_W-1:0] w_rdata;
   logic               w_head_valid;

   assign w_accept   = im_ack & (r_state == ST_BUSY);
   assign w_push     = w_accept & ~redir_valid;
   // A same-cycle pop is not credited, so a full queue waits one cycle before refetching.
   assign w_cnt_push = w_count + CW'(w_push);
   assign w_room     = (w_cnt_push < L_DEPTH);

   assign w_wentry.instr = im_rdata;
   assign w_wentry.pc4   = r_fetch_pc + 32'(WORD_BYTES);

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_clear (redir_valid),
      .i_push  (w_push),
      .i_wdata (w_wentry),
      .i_pop   (dq_ready),
      .o_valid (w_head_valid),
      .o_rdata (w_rdata),
      .o_count (w_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!redir_valid && w_room) w_state_nxt = ST_BUSY;
         end
         ST_BUSY: begin
            if (redir_valid)  w_state_nxt = im_ack ? ST_IDLE : ST_DROP;
            else if (im_ack)  w_state_nxt = w_room ? ST_BUSY : ST_IDLE;
         end
         ST_DROP: begin
            if (im_ack) w_state_nxt = (!redir_valid && w_room) ? ST_BUSY : ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      im_req = (r_state == ST_BUSY);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             r_fetch_pc <= RESET_PC;
      else if (redir_valid) r_fetch_pc <= redir_addr;
      else if (w_accept)    r_fetch_pc <= r_fetch_pc + 32'(WORD_BYTES);
   end

   assign w_head   = fq_entry_t'(w_rdata);
   assign im_addr  = r_fetch_pc;
   assign dq_valid = w_head_valid;
   assign dq_instr = w_head.instr;
   assign dq_pc4   = w_head.pc4;
   assign count    = w_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: random-latency memory, queue-based reference of the prefetch rules.
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ack = 1'b0;
   logic [31:0] im_rdata = 32'h0;
   logic        dq_valid;
   logic [31:0] dq_instr;
   logic [31:0] dq_pc4;
   logic        dq_ready = 1'b0;
   logic        redir_valid = 1'b0;
   logic [31:0] redir_addr = 32'h0;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   exp_t        exp_q[$];
   logic [31:0] m_pc   = RESET_PC;
   logic        m_pend = 1'b0;
   logic        m_drop = 1'b0;
   logic        beef_seen = 1'b0;

   // memory knobs and state
   int          lat_min = 1;
   int          lat_max = 1;
   logic        slow_en = 1'b0;
   logic [31:0] slow_addr = 32'h0;
   logic        mem_busy = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   int          mem_delay = 0;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .im_req      (im_req),
      .im_addr     (im_addr),
      .im_ack      (im_ack),
      .im_rdata    (im_rdata),
      .dq_valid    (dq_valid),
      .dq_instr    (dq_instr),
      .dq_pc4      (dq_pc4),
      .dq_ready    (dq_ready),
      .redir_valid (redir_valid),
      .redir_addr  (redir_addr),
      .count       (count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_pc   = RESET_PC;
      m_pend = 1'b0;
      m_drop = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   // Memory: accepts one request, answers after a random number of cycles, even if abandoned by redirect.
   always @(negedge clk or negedge rst) begin
      if (!rst) begin
         mem_busy = 1'b0;
         im_ack   = 1'b0;
      end else begin
         if (im_ack) im_ack = 1'b0;
         if (!mem_busy && im_req) begin
            mem_busy  = 1'b1;
            mem_addr  = im_addr;
            mem_delay = (slow_en && im_addr == slow_addr) ? 3 : $urandom_range(lat_max, lat_min);
         end
         if (mem_busy) begin
            if (mem_delay == 0) begin
               im_ack   = 1'b1;
               im_rdata = (slow_en && mem_addr == slow_addr) ? 32'hDEAD_BEEF : mem_word(mem_addr);
               mem_busy = 1'b0;
            end else begin
               mem_delay--;
            end
         end
      end
   end

   // Reference model: advances on each edge from the stimulus it sees, pushing expected entries.
   always @(posedge clk) begin
      int   n_pre;
      logic pushed;
      exp_t e;
      if (rst) begin
         n_pre  = exp_q.size();
         pushed = 1'b0;
         if (redir_valid) begin
            if (im_ack)      m_drop = 1'b0;
            else if (m_pend) m_drop = 1'b1;
            exp_q.delete();
            m_pc   = redir_addr;
            m_pend = 1'b0;
         end else begin
            if (im_ack && m_drop) begin
               m_drop = 1'b0;
            end else if (im_ack && m_pend) begin
               e.instr = mem_word(m_pc);
               e.pc4   = m_pc + 32'd4;
               exp_q.push_back(e);
               m_pc   = m_pc + 32'd4;
               m_pend = 1'b0;
               pushed = 1'b1;
            end
            if (n_pre > 0 && dq_ready) void'(exp_q.pop_front());
            if (!m_pend && !m_drop && (n_pre + int'(pushed)) < DEPTH) m_pend = 1'b1;
         end
      end
   end

   // Monitor: compares presented head and request against the model every cycle.
   always @(negedge clk) begin
      if (rst) begin
         check("count", 64'(count), 64'(exp_q.size()));
         check("dq_valid", 64'(dq_valid), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            check("dq_instr", 64'(dq_instr), 64'(exp_q[0].instr));
            check("dq_pc4", 64'(dq_pc4), 64'(exp_q[0].pc4));
         end else begin
            check("empty_head", {dq_instr, dq_pc4}, 64'h0);
         end
         check("im_req", 64'(im_req), 64'(m_pend));
         if (m_pend) check("im_addr", 64'(im_addr), 64'(m_pc));
         if (dq_valid && dq_instr == 32'hDEAD_BEEF) beef_seen = 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          k;
      logic [31:0] max_addr;

      // streaming from reset, 1-cycle memory latency
      lat_min = 1; lat_max = 1; dq_ready = 1'b1;
      do_reset();
      tick();
      check("first_req", 64'(im_req), 64'h1);
      check("first_addr", 64'(im_addr), 64'(RESET_PC));
      k = 0;
      while (!dq_valid && k < 20) begin tick(); k++; end
      check("first_valid_lat", 64'(k), 64'd2);
      check("first_pc4", 64'(dq_pc4), 64'h4);
      check("first_instr", 64'(dq_instr), 64'(mem_word(32'h0)));
      repeat (20) tick();

      // back-pressure: queue fills to DEPTH and fetching stops
      dq_ready = 1'b0;
      do_reset();
      max_addr = 32'h0;
      repeat (20) begin
         tick();
         if (im_req && im_addr > max_addr) max_addr = im_addr;
      end
      check("full_count", 64'(count), 64'(DEPTH));
      check("full_no_req", 64'(im_req), 64'h0);
      check("full_max_addr", 64'(max_addr), 64'hC);
      dq_ready = 1'b1;
      k = 0;
      while (!im_req && k < 20) begin tick(); k++; end
      check("resume_addr", 64'(im_addr), 64'h10);

      // redirect with count=3 and nothing pending
      dq_ready = 1'b0;
      k = 0;
      while (!(count == 3'd4 && !im_req) && k < 40) begin tick(); k++; end
      check("refill_wait", 64'(k < 40), 64'h1);
      dq_ready = 1'b1;
      tick();
      dq_ready = 1'b0;
      check("pre_redir_count", 64'(count), 64'h3);
      check("pre_redir_req", 64'(im_req), 64'h0);
      redir_valid = 1'b1; redir_addr = 32'h0000_0100;
      tick();
      redir_valid = 1'b0;
      check("redir_valid_clr", 64'(dq_valid), 64'h0);
      check("redir_count_clr", 64'(count), 64'h0);
      tick();
      check("redir_req", 64'(im_req), 64'h1);
      check("redir_addr", 64'(im_addr), 64'h100);
      dq_ready = 1'b1;
      k = 0;
      while (!dq_valid && k < 20) begin tick(); k++; end
      check("redir_pc4", 64'(dq_pc4), 64'h104);

      // redirect while a slow request is in flight; its data must be dropped
      slow_en = 1'b1; slow_addr = 32'h10; beef_seen = 1'b0;
      do_reset();
      k = 0;
      while (!(im_req && im_addr == 32'h10) && k < 40) begin tick(); k++; end
      check("slow_wait", 64'(k < 40), 64'h1);
      redir_valid = 1'b1; redir_addr = 32'h0000_0200;
      tick();
      redir_valid = 1'b0;
      check("drop_no_req", 64'(im_req), 64'h0);
      k = 0;
      while (!im_req && k < 20) begin tick(); k++; end
      check("drop_next_addr", 64'(im_addr), 64'h200);
      repeat (10) tick();
      check("beef_dropped", 64'(beef_seen), 64'h0);
      slow_en = 1'b0;

      // redirect coinciding with ack and pop
      lat_min = 0; lat_max = 0;
      k = 0;
      while (!(im_ack && dq_valid) && k < 40) begin tick(); k++; end
      check("coincide_wait", 64'(k < 40), 64'h1);
      redir_valid = 1'b1; redir_addr = 32'h0000_0300;
      tick();
      redir_valid = 1'b0;
      check("coincide_count", 64'(count), 64'h0);
      check("coincide_no_req", 64'(im_req), 64'h0);
      tick();
      check("coincide_req", 64'(im_req), 64'h1);
      check("coincide_addr", 64'(im_addr), 64'h300);

      // asynchronous reset mid-request
      lat_min = 1; lat_max = 1; dq_ready = 1'b0;
      do_reset();
      k = 0;
      while (!(count == 3'd2 && im_req) && k < 40) begin tick(); k++; end
      check("midrst_wait", 64'(k < 40), 64'h1);
      #2 rst = 1'b0;
      #1;
      check("midrst_req", 64'(im_req), 64'h0);
      check("midrst_valid", 64'(dq_valid), 64'h0);
      check("midrst_count", 64'(count), 64'h0);
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      dq_ready = 1'b1;
      tick();
      check("midrst_first_addr", {31'h0, im_req, im_addr}, {31'h0, 1'b1, RESET_PC});

      // randomized traffic, including misaligned and wrapping redirect targets
      lat_min = 0; lat_max = 3;
      for (int i = 0; i < 2500; i++) begin
         dq_ready = ($urandom % 4) != 0;
         if ($urandom % 16 == 0) begin
            int sel;
            sel = $urandom % 8;
            redir_valid = 1'b1;
            if (sel == 0)      redir_addr = 32'hFFFF_FFF4;
            else if (sel == 1) redir_addr = $urandom;
            else               redir_addr = $urandom & 32'h0000_FFFC;
         end else begin
            redir_valid = 1'b0;
         end
         tick();
      end
      redir_valid = 1'b0;
      repeat (10) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
